// File: rtl/imem_responder.sv
// rtl/imem_responder.sv - instruction-memory responder with deterministic grant/rvalid latencies
// Optional feature macro: IMEM_RAND_STALL_EN (LFSR-driven random grant suppression)
module imem_responder #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MEM_DEPTH       = 1024,
  parameter int GNT_LATENCY     = 0,
  parameter int RVALID_LATENCY  = 1,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req,
  input  logic [ADDR_WIDTH-1:0] instr_addr,
  output logic                  instr_grant,
  output logic                  instr_rvalid,
  output logic [DATA_WIDTH-1:0] instr_rdata,
  input  logic                  load_we,
  input  logic [ADDR_WIDTH-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0] load_data
);

  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [3:0]            wait_cnt_q, wait_cnt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [CW-1:0]         pos;
  logic [DATA_WIDTH-1:0] fifo_data_q [MAX_OUTSTANDING];
  logic [DATA_WIDTH-1:0] fifo_data_d [MAX_OUTSTANDING];
  logic [3:0]            fifo_age_q  [MAX_OUTSTANDING];
  logic [3:0]            fifo_age_d  [MAX_OUTSTANDING];

  logic                  stall;
  logic                  pop;
  logic                  rd_in_range;
  logic                  ld_in_range;
  logic [DATA_WIDTH-1:0] rd_word;

  // Word indices beyond the store read as zero and swallow writes
  assign rd_in_range = (instr_addr >> 2) < ADDR_WIDTH'(MEM_DEPTH);
  assign ld_in_range = (load_addr  >> 2) < ADDR_WIDTH'(MEM_DEPTH);
  assign rd_word     = rd_in_range ? mem[instr_addr[IW+1:2]] : '0;

`ifdef IMEM_RAND_STALL_EN
  logic [7:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR x^8+x^6+x^5+x^4+1, restarts from the same seed on every reset
  always_comb begin
    lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  end

  // LFSR state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= 8'hA5;
    else        lfsr_q <= lfsr_d;
  end

  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // Grant is combinational; rst_n gating keeps it low while reset is held
  assign instr_grant = rst_n && instr_req && !stall &&
                       (wait_cnt_q == 4'(GNT_LATENCY)) &&
                       (cnt_q < CW'(MAX_OUTSTANDING));

  // Head of the pending FIFO leaves exactly when it has aged RVALID_LATENCY cycles
  assign pop          = (cnt_q != '0) && (fifo_age_q[0] == 4'(RVALID_LATENCY));
  assign instr_rvalid = pop;
  assign instr_rdata  = pop ? fifo_data_q[0] : '0;

  // Request wait counter: saturates while a request is held ungranted
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!instr_req || instr_grant) wait_cnt_d = '0;
    else if (wait_cnt_q != 4'(GNT_LATENCY)) wait_cnt_d = wait_cnt_q + 4'd1;
  end

  // Pending FIFO: age live entries, shift on pop, append the granted word behind
  always_comb begin
    fifo_data_d = fifo_data_q;
    fifo_age_d  = fifo_age_q;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (CW'(i) < cnt_q) fifo_age_d[i] = fifo_age_q[i] + 4'd1;
    end
    if (pop) begin
      for (int i = 0; i < MAX_OUTSTANDING - 1; i++) begin
        fifo_data_d[i] = fifo_data_d[i+1];
        fifo_age_d[i]  = fifo_age_d[i+1];
      end
    end
    pos = pop ? cnt_q - CW'(1) : cnt_q;
    if (instr_grant) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        if (CW'(i) == pos) begin
          fifo_data_d[i] = rd_word;
          fifo_age_d[i]  = 4'd1;
        end
      end
    end
    cnt_d = instr_grant ? pos + CW'(1) : pos;
  end

  // Control and FIFO state; reset drops every pending read
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_data_q[i] <= '0;
        fifo_age_q[i]  <= '0;
      end
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      cnt_q       <= cnt_d;
      fifo_data_q <= fifo_data_d;
      fifo_age_q  <= fifo_age_d;
    end
  end

  // Preload port; the store itself is never cleared by reset
  always_ff @(posedge clk) begin
    if (load_we && ld_in_range) mem[load_addr[IW+1:2]] <= load_data;
  end

endmodule

// File: tb/tb_imem_responder.sv
// tb/tb_imem_responder.sv - scoreboard bench for imem_responder across three latency configurations
module tb_imem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        load_we;
  logic [31:0] load_addr, load_data;
  logic        req0, req1, req2;
  logic [31:0] addr0, addr1, addr2;
  logic        gnt0, gnt1, gnt2;
  logic        rv0, rv1, rv2;
  logic [31:0] rd0, rd1, rd2;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t e0, e1, e2;

  logic [31:0] model [0:1023];

  // d0: defaults (GNT 0, RVALID 1, MAX_OUT 2)
  imem_responder u_d0 (
    .clk(clk), .rst_n(rst_n), .instr_req(req0), .instr_addr(addr0),
    .instr_grant(gnt0), .instr_rvalid(rv0), .instr_rdata(rd0),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  // d1: slow grant, slow return
  imem_responder #(.GNT_LATENCY(2), .RVALID_LATENCY(3), .MAX_OUTSTANDING(2)) u_d1 (
    .clk(clk), .rst_n(rst_n), .instr_req(req1), .instr_addr(addr1),
    .instr_grant(gnt1), .instr_rvalid(rv1), .instr_rdata(rd1),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  // d2: immediate grant, slow return, fills up
  imem_responder #(.GNT_LATENCY(0), .RVALID_LATENCY(3), .MAX_OUTSTANDING(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .instr_req(req2), .instr_addr(addr2),
    .instr_grant(gnt2), .instr_rvalid(rv2), .instr_rdata(rd2),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] mdl(input logic [31:0] a);
    if ((a >> 2) >= 32'd1024) return 32'h0;
    return model[a[11:2]];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push(input int which, input logic [31:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    case (which)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    tick();
    load_we   = 1'b1;
    load_addr = a;
    load_data = d;
    if ((a >> 2) < 32'd1024) model[a[11:2]] = d;
    tick();
    load_we = 1'b0;
  endtask

  task automatic fetch0(input logic [31:0] a);
    tick();
    req0  = 1'b1;
    addr0 = a;
    smp();
    chk("d0_gnt", 32'(gnt0), 32'd1);
    push(0, mdl(a), cyc + 1);
    tick();
    req0 = 1'b0;
  endtask

  // Return monitors: every rvalid must match the scoreboard head in data and cycle
  always @(negedge clk) begin
    if (rv0) begin
      if (q0.size() == 0) chk("d0_spurious_rvalid", 32'(rv0), 32'd0);
      else begin
        e0 = q0.pop_front();
        chk("d0_rdata", rd0, e0.data);
        chk("d0_rv_cycle", 32'(cyc), 32'(e0.cyc));
      end
    end else chk("d0_rdata_idle", rd0, 32'd0);
  end

  always @(negedge clk) begin
    if (rv1) begin
      if (q1.size() == 0) chk("d1_spurious_rvalid", 32'(rv1), 32'd0);
      else begin
        e1 = q1.pop_front();
        chk("d1_rdata", rd1, e1.data);
        chk("d1_rv_cycle", 32'(cyc), 32'(e1.cyc));
      end
    end else chk("d1_rdata_idle", rd1, 32'd0);
  end

  always @(negedge clk) begin
    if (rv2) begin
      if (q2.size() == 0) chk("d2_spurious_rvalid", 32'(rv2), 32'd0);
      else begin
        e2 = q2.pop_front();
        chk("d2_rdata", rd2, e2.data);
        chk("d2_rv_cycle", 32'(cyc), 32'(e2.cyc));
      end
    end else chk("d2_rdata_idle", rd2, 32'd0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1; load_we = 1'b0; load_addr = '0; load_data = '0;
    req0 = 1'b1; addr0 = 32'h10;
    req1 = 1'b0; addr1 = '0;
    req2 = 1'b0; addr2 = '0;
    #1 rst_n = 1'b0;

    // preload while reset is held, with d0 requesting throughout
    load(32'h10, 32'hDEADBEEF);
    load(32'h20, 32'h22222222);
    load(32'h00, 32'h10000001);
    load(32'h04, 32'h20000002);
    load(32'h08, 32'h30000003);
    smp();
    chk("rst_gnt0",   32'(gnt0), 32'd0);
    chk("rst_rvalid", 32'(rv0),  32'd0);
    chk("rst_rdata",  rd0,       32'd0);

    // release: held request is granted in the first cycle
    tick(); rst_n = 1'b1;
    smp();
    chk("rel_gnt0", 32'(gnt0), 32'd1);
    push(0, 32'hDEADBEEF, cyc + 1);
    tick(); req0 = 1'b0;
    smp();
    chk("d0_gnt_idle", 32'(gnt0), 32'd0);

    // single fetches, ignored low bits, out-of-range index
    fetch0(32'h10);
    fetch0(32'h13);
    fetch0(32'd4096);

    // same-cycle grant and load to one word returns the old data
    tick();
    req0 = 1'b1; addr0 = 32'h20;
    load_we = 1'b1; load_addr = 32'h20; load_data = 32'h11111111;
    smp();
    chk("d0_coll_gnt", 32'(gnt0), 32'd1);
    push(0, mdl(32'h20), cyc + 1);
    model[8] = 32'h11111111;
    tick(); req0 = 1'b0; load_we = 1'b0;
    fetch0(32'h20);

    // sustained one grant per cycle on d0
    tick(); req0 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      addr0 = 32'(4 * i);
      smp();
      chk("d0_b2b_gnt", 32'(gnt0), 32'd1);
      push(0, mdl(32'(4 * i)), cyc + 1);
      tick();
    end
    req0 = 1'b0;

    // d1 latency: grant two cycles after req rises, rvalid three after grant
    tick(); req1 = 1'b1; addr1 = 32'h0;
    smp(); chk("d1_gnt_w0", 32'(gnt1), 32'd0);
    tick(); smp(); chk("d1_gnt_w1", 32'(gnt1), 32'd0);
    tick(); smp(); chk("d1_gnt", 32'(gnt1), 32'd1);
    push(1, mdl(32'h0), cyc + 3);
    tick(); req1 = 1'b0;

    // d2 back-to-back until full, no bypass on the freeing cycle
    tick(); req2 = 1'b1; addr2 = 32'h0;
    smp(); chk("d2_gnt_a", 32'(gnt2), 32'd1);
    push(2, mdl(32'h0), cyc + 3);
    tick(); addr2 = 32'h4;
    smp(); chk("d2_gnt_b", 32'(gnt2), 32'd1);
    push(2, mdl(32'h4), cyc + 3);
    tick(); addr2 = 32'h8;
    smp(); chk("d2_full_stall", 32'(gnt2), 32'd0);
    tick(); smp(); chk("d2_no_bypass", 32'(gnt2), 32'd0);
    tick(); smp(); chk("d2_gnt_c", 32'(gnt2), 32'd1);
    push(2, mdl(32'h8), cyc + 3);
    tick(); req2 = 1'b0;
    repeat (6) tick();

    // reset one cycle after a d2 grant: read dropped, counters restart
    req2 = 1'b1; addr2 = 32'h4;
    smp(); chk("d2_pre_rst_gnt", 32'(gnt2), 32'd1);
    tick(); req2 = 1'b0; rst_n = 1'b0; req1 = 1'b1; addr1 = 32'h10;
    smp(); chk("rst_gnt1", 32'(gnt1), 32'd0);
    tick(); smp(); chk("rst_gnt2", 32'(gnt2), 32'd0);
    tick(); rst_n = 1'b1; req2 = 1'b1; addr2 = 32'h0;
    smp();
    chk("d1_post_rst_w0", 32'(gnt1), 32'd0);
    chk("d2_post_rst_a",  32'(gnt2), 32'd1);
    push(2, mdl(32'h0), cyc + 3);
    tick(); addr2 = 32'h4;
    smp();
    chk("d1_post_rst_w1", 32'(gnt1), 32'd0);
    chk("d2_post_rst_b",  32'(gnt2), 32'd1);
    push(2, mdl(32'h4), cyc + 3);
    tick(); req2 = 1'b0;
    smp();
    chk("d1_post_rst_gnt", 32'(gnt1), 32'd1);
    push(1, mdl(32'h10), cyc + 3);
    tick(); req1 = 1'b0;

    repeat (8) tick();
    smp();
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q1_drained", 32'(q1.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
